piso_arb_ctrl: RTL

PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

---
 rtl/piso_arb_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin arbiter feeding an LSB-first parallel-to-serial shifter.
module piso_arb_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_src,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             last_grant, last_grant_nxt;
  logic             ser_out_nxt, ser_valid_nxt, ser_src_nxt;
  logic             grant;
  logic [WIDTH-1:0] word;

  // Round-robin pick: on a tie favour the requester not served last.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end
  end

  assign word = grant ? req1_data : req0_data;
  assign busy = (state == SHIFT);

  // Next-state, combinational readies and next values of the serial outputs.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    ser_out_nxt    = 1'b0;
    ser_valid_nxt  = 1'b0;
    ser_src_nxt    = ser_src;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;

    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready     = ~grant;
          req1_ready     = grant;
          state_nxt      = SHIFT;
          // Bit 0 goes out immediately; the remainder waits in the shifter.
          shreg_nxt      = word >> 1;
          ser_out_nxt    = word[0];
          ser_valid_nxt  = 1'b1;
          ser_src_nxt    = grant;
          last_grant_nxt = grant;
          cnt_nxt        = CW'(1);
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          ser_out_nxt   = shreg[0];
          ser_valid_nxt = 1'b1;
          shreg_nxt     = shreg >> 1;
          cnt_nxt       = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      ser_src    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      ser_out    <= ser_out_nxt;
      ser_valid  <= ser_valid_nxt;
      ser_src    <= ser_src_nxt;
    end
  end

endmodule
